// File: rtl/midi_gate_ctrl_pkg.sv
// midi_gate_ctrl_pkg: MIDI status constants, parser state encoding and byte-class helper.
package midi_gate_ctrl_pkg;
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON = 4'h9;
  localparam logic [3:0] CC = 4'hB;
  localparam logic [3:0] PROG = 4'hC;
  localparam logic [3:0] CHAN_PRESS = 4'hD;
  localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;
  typedef enum logic [1:0] {NO_STATUS, WAIT_D1, WAIT_D2} pstate_t;
  function automatic logic one_data(input logic [3:0] hi);
    return hi == PROG || hi == CHAN_PRESS;
  endfunction
endpackage

// File: rtl/midi_gate_ctrl_if.sv
// midi_gate_ctrl_if: byte stream in, gate strobes and note/velocity out.
interface midi_gate_ctrl_if;
  logic [7:0] midi_byte;
  logic midi_dv;
  logic gate_on;
  logic gate_off;
  logic gate;
  logic [6:0] note;
  logic [6:0] velocity;
  modport master(output midi_byte, midi_dv, input gate_on, gate_off, gate, note, velocity);
  modport slave(input midi_byte, midi_dv, output gate_on, gate_off, gate, note, velocity);
endinterface

// File: rtl/midi_gate_ctrl_msg_parser.sv
// midi_msg_parser: running-status MIDI parser; msg_dv fires in the cycle carrying the final data byte.
module midi_msg_parser
  import midi_gate_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] midi_byte,
  input  logic       midi_dv,
  output logic       msg_dv,
  output logic [7:0] msg_status,
  output logic [6:0] msg_d1,
  output logic [6:0] msg_d2
);
  pstate_t state, state_nx;
  logic [7:0] status, status_nx;
  logic [6:0] d1, d1_nx;
  logic sys, stat, data;
  // Realtime bytes (F8-FF) fall in none of these classes and leave everything untouched.
  assign sys = midi_dv && midi_byte[7:3] == 5'b11110;
  assign stat = midi_dv && midi_byte[7] && midi_byte[7:4] != 4'hF;
  assign data = midi_dv && !midi_byte[7];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= NO_STATUS;
      status <= 8'h00;
      d1 <= 7'h00;
    end else begin
      state <= state_nx;
      status <= status_nx;
      d1 <= d1_nx;
    end
  always_comb begin
    state_nx = sys ? NO_STATUS : stat ? WAIT_D1 : !data ? state :
               (state == WAIT_D1 && !one_data(status[7:4])) ? WAIT_D2 :
               state == WAIT_D2 ? WAIT_D1 : state;
    status_nx = sys ? 8'h00 : stat ? midi_byte : status;
    d1_nx = data ? midi_byte[6:0] : d1;
  end
  always_comb begin
    msg_dv = data && (state == WAIT_D2 || (state == WAIT_D1 && one_data(status[7:4])));
    msg_status = status;
    msg_d1 = state == WAIT_D2 ? d1 : midi_byte[6:0];
    msg_d2 = midi_byte[6:0];
  end
endmodule

// File: rtl/midi_gate_ctrl.sv
// midi_gate_ctrl: channel filter and last-note-priority gate tracker driving the envelope strobes.
module midi_gate_ctrl
  import midi_gate_ctrl_pkg::*;
#(
  parameter logic [3:0] MIDI_CH = 4'd0
) (
  input logic clk,
  input logic rst_n,
  midi_gate_ctrl_if.slave bus
);
  logic msg_dv, ch_ok, hit_on, hit_off, rel, all_off;
  logic [7:0] msg_status;
  logic [6:0] msg_d1, msg_d2;
  logic [3:0] kind;
  midi_msg_parser u_parser (
    .clk(clk),
    .rst_n(rst_n),
    .midi_byte(bus.midi_byte),
    .midi_dv(bus.midi_dv),
    .msg_dv(msg_dv),
    .msg_status(msg_status),
    .msg_d1(msg_d1),
    .msg_d2(msg_d2)
  );
  assign kind = msg_status[7:4];
  assign ch_ok = msg_dv && msg_status[3:0] == MIDI_CH;
  assign rel = (kind == NOTE_OFF || (kind == NOTE_ON && msg_d2 == 7'd0)) && msg_d1 == bus.note;
  assign all_off = kind == CC && (msg_d1 == CC_ALL_NOTES_OFF || msg_d1 == CC_ALL_SOUND_OFF);
  assign hit_on = ch_ok && kind == NOTE_ON && msg_d2 != 7'd0;
  assign hit_off = ch_ok && bus.gate && (rel || all_off);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.gate_on <= 1'b0;
      bus.gate_off <= 1'b0;
      bus.gate <= 1'b0;
      bus.note <= 7'd0;
      bus.velocity <= 7'd0;
    end else begin
      bus.gate_on <= hit_on;
      bus.gate_off <= hit_off;
      bus.gate <= hit_on ? 1'b1 : hit_off ? 1'b0 : bus.gate;
      if (hit_on) begin
        bus.note <= msg_d1;
        bus.velocity <= msg_d2;
      end
    end
endmodule
